pll_lock_sequencer: RTL and testbench
=====================================

# pll_lock_sequencer

Controller for the iCE40 PLL wrapper and the reset tree it feeds. Runs on the free-running 16 MHz reference clock and drives the PLL's active-low reset. It qualifies the PLL lock indication before releasing the downstream system reset, and re-sequences automatically on loss of lock or lock timeout. It sits between the board clock pin, the PLL wrapper's `RESETB`/`locked` pins, and the reset input of every peripheral in the PLL clock domain.

## Interface
Parameters:
- `PLL_RST_CYCLES`, 16: cycles `pll_resetb` is held low per PLL reset pulse (≥1).
- `LOCK_STABLE_CYCLES`, 1024: consecutive synchronized-lock-high cycles required before release (≥1).
- `LOCK_TIMEOUT`, 65536: cycles waiting for lock before re-pulsing PLL reset (≥1).
- `CNT_W`, 17: state-counter width; every cycle parameter must be ≤ 2^CNT_W.

Ports:
- `clk`, in, 1: reference clock (16 MHz, not the PLL output).
- `reset`, in, 1: synchronous, active-high.
- `pll_locked`, in, 1: PLL lock output, asynchronous to `clk`.
- `pll_resetb`, out, 1: to PLL `RESETB`, active-low.
- `sys_reset`, out, 1: active-high reset for the PLL-domain logic (consumers resynchronize).
- `ready`, out, 1: high in RUN only.
- `state`, out, 2: current state code.
- `relock_count`, out, 8: lock losses from RUN, saturates at 255.
- `timeout_count`, out, 8: lock timeouts, saturates at 255.

## Operation
- `pll_locked` passes through a 2-flop synchronizer (flops reset to 0) to give `lock_s`. Only `lock_s` is used.
- States: PLL_RST=0, WAIT_LOCK=1, STABLE=2, RUN=3. A single counter `cnt` clears to 0 on every state entry and increments each cycle in the state.
- PLL_RST:
  - `pll_resetb`=0.
  - When `cnt`==PLL_RST_CYCLES-1, go to WAIT_LOCK.
- WAIT_LOCK:
  - If `lock_s`=1, go to STABLE.
  - Else if `cnt`==LOCK_TIMEOUT-1, go to PLL_RST and increment `timeout_count`.
  - `lock_s`=1 wins over the timeout in the same cycle.
- STABLE:
  - If `lock_s`=0, go to WAIT_LOCK with no counter increment.
  - Else if `cnt`==LOCK_STABLE_CYCLES-1, go to RUN.
  - Lock drop wins on the final count.
- RUN:
  - If `lock_s`=0, go to WAIT_LOCK and increment `relock_count`.
  - Otherwise stay; `cnt` holds (no wrap).
- Outputs are registered and computed from the next state, so they change on the same edge as `state`:
  - `pll_resetb` = (next≠PLL_RST)
  - `sys_reset` = (next≠RUN)
  - `ready` = (next==RUN)
- Counters saturate at 255 and never wrap. They clear only on `reset`.
- `reset`=1 at any time, including mid-sequence, forces the reset values below on the next edge. It overrides all transitions.
- Reset values:
  - state=PLL_RST, `cnt`=0
  - `pll_resetb`=0, `sys_reset`=1, `ready`=0
  - `relock_count`=0, `timeout_count`=0
  - synchronizer=0

## Timing
- Lock input latency: a `pll_locked` change is visible in `lock_s` 2 edges later.
- PLL reset pulse width is exactly PLL_RST_CYCLES cycles.
- With `pll_locked` held high throughout, `sys_reset` falls exactly PLL_RST_CYCLES+1+LOCK_STABLE_CYCLES edges after the first edge with `reset`=0. This count holds because `lock_s` is already 1 by WAIT_LOCK when PLL_RST_CYCLES≥2.
- Loss of lock in RUN:
  - `sys_reset` rises and `ready` falls 3 edges after `pll_locked` falls (2 synchronizer edges + 1 state edge).
  - `relock_count` updates on the same edge.
- Timeout period: a non-locking PLL is re-pulsed every PLL_RST_CYCLES+LOCK_TIMEOUT cycles.
- A glitch on `lock_s` during STABLE restarts qualification from WAIT_LOCK. The full LOCK_STABLE_CYCLES must elapse again.

## Test plan
All scenarios use PLL_RST_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT=32.
1. Clean bring-up: `pll_locked`=1, release `reset` → `pll_resetb` low for exactly 4 cycles. `sys_reset` falls and `ready` rises at edge 13. Both counters stay 0.
2. Lock timeout: hold `pll_locked`=0 → PLL_RST re-entered every 36 cycles. `timeout_count` reads 1, 2, 3; with `pll_locked` held 0 long enough it saturates at 255 and stays there.
3. Stability glitch: `pll_locked` 0 for one cycle at STABLE `cnt`=7 → returns to WAIT_LOCK, then needs 8 more STABLE cycles. `ready` stays 0 until then.
4. Loss of lock in RUN: drop `pll_locked` → `sys_reset`=1 and `ready`=0 exactly 3 edges later, `relock_count`=1. Restore lock → RUN again after 1+8 cycles.
5. Reset mid-sequence: assert `reset` at STABLE `cnt`=5 → next edge state=0, `pll_resetb`=0, `sys_reset`=1, both counters 0.
6. Simultaneous events: `lock_s` rises on WAIT_LOCK `cnt`=31 → goes to STABLE and `timeout_count` is unchanged.

Source files
------------

// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock sequencer: pulses the PLL reset, qualifies the synchronized lock
// indication, and only then releases the reset of the PLL clock domain.
module pll_lock_sequencer #(
  parameter int unsigned PLL_RST_CYCLES     = 16,
  parameter int unsigned LOCK_STABLE_CYCLES = 1024,
  parameter int unsigned LOCK_TIMEOUT       = 65536,
  parameter int unsigned CNT_W              = 17
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pll_locked,
  output logic       pll_resetb,
  output logic       sys_reset,
  output logic       ready,
  output logic [1:0] state,
  output logic [7:0] relock_count,
  output logic [7:0] timeout_count
);

  typedef enum logic [1:0] {
    PLL_RST   = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);

  logic             lock_meta_q;
  logic             lock_s_q;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       relock_q, relock_d;
  logic [7:0]       timeout_q, timeout_d;
  logic             pll_resetb_q, pll_resetb_d;
  logic             sys_reset_q, sys_reset_d;
  logic             ready_q, ready_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CNT_W'(1);
    relock_d  = relock_q;
    timeout_d = timeout_q;

    case (state_q)
      PLL_RST: begin
        if (cnt_q == RST_LAST) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end
      end
      WAIT_LOCK: begin
        // A lock arriving on the last timeout count takes priority over the re-pulse.
        if (lock_s_q) begin
          state_d = STABLE;
          cnt_d   = '0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d = PLL_RST;
          cnt_d   = '0;
          if (timeout_q != '1) timeout_d = timeout_q + 8'd1;
        end
      end
      STABLE: begin
        if (!lock_s_q) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN: begin
        cnt_d = cnt_q;
        if (!lock_s_q) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
          if (relock_q != '1) relock_d = relock_q + 8'd1;
        end
      end
      default: begin
        state_d = PLL_RST;
        cnt_d   = '0;
      end
    endcase

    // Registered outputs track the next state so they switch with state_q.
    pll_resetb_d = (state_d != PLL_RST);
    sys_reset_d  = (state_d != RUN);
    ready_d      = (state_d == RUN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lock_meta_q  <= 1'b0;
      lock_s_q     <= 1'b0;
      state_q      <= PLL_RST;
      cnt_q        <= '0;
      relock_q     <= '0;
      timeout_q    <= '0;
      pll_resetb_q <= 1'b0;
      sys_reset_q  <= 1'b1;
      ready_q      <= 1'b0;
    end else begin
      lock_meta_q  <= pll_locked;
      lock_s_q     <= lock_meta_q;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      relock_q     <= relock_d;
      timeout_q    <= timeout_d;
      pll_resetb_q <= pll_resetb_d;
      sys_reset_q  <= sys_reset_d;
      ready_q      <= ready_d;
    end
  end

  assign pll_resetb    = pll_resetb_q;
  assign sys_reset     = sys_reset_q;
  assign ready         = ready_q;
  assign state         = state_q;
  assign relock_count  = relock_q;
  assign timeout_count = timeout_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer with PLL_RST=4, STABLE=8, TIMEOUT=32;
// edge numbers count posedges after reset release.
module tb_pll_lock_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       pll_locked;
  logic       pll_resetb;
  logic       sys_reset;
  logic       ready;
  logic [1:0] state;
  logic [7:0] relock_count;
  logic [7:0] timeout_count;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;
  int          cyc     = 0;
  int          e;

  always #5 clk = ~clk;

  pll_lock_sequencer #(
    .PLL_RST_CYCLES    (4),
    .LOCK_STABLE_CYCLES(8),
    .LOCK_TIMEOUT      (32),
    .CNT_W             (17)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .pll_locked   (pll_locked),
    .pll_resetb   (pll_resetb),
    .sys_reset    (sys_reset),
    .ready        (ready),
    .state        (state),
    .relock_count (relock_count),
    .timeout_count(timeout_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic go(input int target);
    while (cyc < target) tick();
  endtask

  task automatic start(input logic lk);
    reset      = 1'b1;
    pll_locked = lk;
    repeat (3) tick();
    reset = 1'b0;
    cyc   = 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0d expected %0d (edge %0d)", tag, obs, exp, cyc);
  endtask

  initial begin
    // Reset state
    start(1'b1);
    chk("rst_state", 32'(state), 0);
    chk("rst_resetb", 32'(pll_resetb), 0);
    chk("rst_sysrst", 32'(sys_reset), 1);
    chk("rst_ready", 32'(ready), 0);
    chk("rst_relock", 32'(relock_count), 0);
    chk("rst_timeout", 32'(timeout_count), 0);

    // 1. Clean bring-up
    go(3);  chk("up_resetb_e3", 32'(pll_resetb), 0);
    go(4);  chk("up_resetb_e4", 32'(pll_resetb), 1);
            chk("up_state_e4", 32'(state), 1);
    go(5);  chk("up_state_e5", 32'(state), 2);
    go(12); chk("up_sysrst_e12", 32'(sys_reset), 1);
            chk("up_ready_e12", 32'(ready), 0);
    go(13); chk("up_sysrst_e13", 32'(sys_reset), 0);
            chk("up_ready_e13", 32'(ready), 1);
            chk("up_state_e13", 32'(state), 3);
            chk("up_relock", 32'(relock_count), 0);
            chk("up_timeout", 32'(timeout_count), 0);

    // 2. Lock timeout and saturation
    start(1'b0);
    go(35);  chk("to_state_e35", 32'(state), 1);
             chk("to_cnt_e35", 32'(timeout_count), 0);
    go(36);  chk("to_state_e36", 32'(state), 0);
             chk("to_resetb_e36", 32'(pll_resetb), 0);
             chk("to_cnt_e36", 32'(timeout_count), 1);
    go(39);  chk("to_resetb_e39", 32'(pll_resetb), 0);
    go(40);  chk("to_resetb_e40", 32'(pll_resetb), 1);
    go(72);  chk("to_cnt_e72", 32'(timeout_count), 2);
             chk("to_state_e72", 32'(state), 0);
    go(108); chk("to_cnt_e108", 32'(timeout_count), 3);
    go(36 * 254); chk("to_cnt_254", 32'(timeout_count), 254);
    go(36 * 255); chk("to_cnt_255", 32'(timeout_count), 255);
    go(36 * 258); chk("to_cnt_sat", 32'(timeout_count), 255);
                  chk("to_ready_sat", 32'(ready), 0);

    // 3. Stability glitch: lock_s is 0 during the STABLE cnt=7 cycle
    start(1'b1);
    go(10); pll_locked = 1'b0;
    go(11); pll_locked = 1'b1;
    go(13); chk("gl_state_e13", 32'(state), 1);
            chk("gl_ready_e13", 32'(ready), 0);
    go(14); chk("gl_state_e14", 32'(state), 2);
    go(21); chk("gl_ready_e21", 32'(ready), 0);
            chk("gl_state_e21", 32'(state), 2);
    go(22); chk("gl_ready_e22", 32'(ready), 1);
            chk("gl_state_e22", 32'(state), 3);

    // 4. Loss of lock in RUN
    e = 25;
    go(e);     pll_locked = 1'b0;
    go(e + 2); chk("ll_ready_e2", 32'(ready), 1);
               chk("ll_relock_e2", 32'(relock_count), 0);
    go(e + 3); chk("ll_ready_e3", 32'(ready), 0);
               chk("ll_sysrst_e3", 32'(sys_reset), 1);
               chk("ll_state_e3", 32'(state), 1);
               chk("ll_relock_e3", 32'(relock_count), 1);
               pll_locked = 1'b1;
    go(e + 6);  chk("ll_state_e6", 32'(state), 2);
    go(e + 13); chk("ll_state_e13", 32'(state), 2);
    go(e + 14); chk("ll_state_e14", 32'(state), 3);
                chk("ll_ready_e14", 32'(ready), 1);

    // Second loss, then 5. reset at STABLE cnt=5
    e = 45;
    go(e);      pll_locked = 1'b0;
    go(e + 3);  chk("ll2_relock", 32'(relock_count), 2);
                pll_locked = 1'b1;
    go(e + 11); chk("mr_state_pre", 32'(state), 2);
                reset = 1'b1;
    tick();
    chk("mr_state", 32'(state), 0);
    chk("mr_resetb", 32'(pll_resetb), 0);
    chk("mr_sysrst", 32'(sys_reset), 1);
    chk("mr_ready", 32'(ready), 0);
    chk("mr_relock", 32'(relock_count), 0);
    chk("mr_timeout", 32'(timeout_count), 0);

    // 6. lock_s rises on WAIT_LOCK cnt=31
    start(1'b0);
    go(33); pll_locked = 1'b1;
    go(35); chk("sim_state_e35", 32'(state), 1);
    go(36); chk("sim_state_e36", 32'(state), 2);
            chk("sim_timeout", 32'(timeout_count), 0);
            chk("sim_resetb", 32'(pll_resetb), 1);
    go(44); chk("sim_state_e44", 32'(state), 3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
